predictor_update_sched: RTL

Ticket-ordered scheduler for branch-predictor training in the superscalar IF stage. Resolved-branch updates arrive out of order, each tagged with a 3-bit ticket. The block holds them in an 8-slot ticket-indexed buffer and retires them strictly in ticket order onto the single shared write/update port of the BTB and GShare tables. Fetch-side table reads have priority over these writes, and a starvation guard forces a write when fetch reads keep blocking it.

---
 rtl/predictor_update_sched_if.sv | 40 ++++
 rtl/predictor_update_sched.sv | 105 ++++++++++
 2 files changed

// File: rtl/predictor_update_sched_if.sv
// Handshake bundle between resolved-branch update sources, fetch and the predictor write port.
// The slave modport is the scheduler's view; the master modport is the driver/observer view.
interface predictor_update_sched_if #(
  parameter int unsigned PC_BITS     = 32,
  parameter int unsigned TICKET_BITS = 3
);
  logic                   upd_valid_i;
  logic                   upd_valid_jump_i;
  logic                   upd_jump_taken_i;
  logic [PC_BITS-1:0]     upd_orig_pc_i;
  logic [PC_BITS-1:0]     upd_jump_address_i;
  logic [TICKET_BITS-1:0] upd_ticket_i;
  logic                   flush_i;
  logic [TICKET_BITS-1:0] flush_ticket_i;
  logic                   fetch_rd_i;
  logic                   fetch_stall_o;
  logic                   btb_wr_en_o;
  logic [PC_BITS-1:0]     btb_wr_pc_o;
  logic [PC_BITS-1:0]     btb_wr_target_o;
  logic                   gsh_upd_en_o;
  logic [PC_BITS-1:0]     gsh_upd_pc_o;
  logic                   gsh_upd_taken_o;
  logic [TICKET_BITS-1:0] head_ticket_o;
  logic                   pending_o;
  logic                   err_o;

  modport slave (
    input  upd_valid_i, upd_valid_jump_i, upd_jump_taken_i, upd_orig_pc_i,
    input  upd_jump_address_i, upd_ticket_i, flush_i, flush_ticket_i, fetch_rd_i,
    output fetch_stall_o, btb_wr_en_o, btb_wr_pc_o, btb_wr_target_o,
    output gsh_upd_en_o, gsh_upd_pc_o, gsh_upd_taken_o, head_ticket_o, pending_o, err_o
  );

  modport master (
    output upd_valid_i, upd_valid_jump_i, upd_jump_taken_i, upd_orig_pc_i,
    output upd_jump_address_i, upd_ticket_i, flush_i, flush_ticket_i, fetch_rd_i,
    input  fetch_stall_o, btb_wr_en_o, btb_wr_pc_o, btb_wr_target_o,
    input  gsh_upd_en_o, gsh_upd_pc_o, gsh_upd_taken_o, head_ticket_o, pending_o, err_o
  );
endinterface

// File: rtl/predictor_update_sched.sv
// Ticket-ordered retirement of out-of-order branch resolutions onto the shared BTB/GShare
// write port; fetch reads win the port until a starvation counter forces a write.
module predictor_update_sched #(
  parameter int unsigned PC_BITS      = 32,
  parameter int unsigned TICKET_BITS  = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                     clk,
  input logic                     rst,
  predictor_update_sched_if.slave bus
);
  localparam int unsigned Slots = 2 ** TICKET_BITS;
  localparam int unsigned SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

  logic [Slots-1:0]       r_valid;
  logic [Slots-1:0]       r_jump;
  logic [Slots-1:0]       r_taken;
  logic [PC_BITS-1:0]     r_pc  [Slots];
  logic [PC_BITS-1:0]     r_tgt [Slots];
  logic [TICKET_BITS-1:0] r_head;
  logic [SW-1:0]          r_starve;
  logic                   r_err;

  logic               w_head_valid;
  logic               w_head_jump;
  logic               w_head_taken;
  logic [PC_BITS-1:0] w_head_pc;
  logic [PC_BITS-1:0] w_head_tgt;
  logic               w_force;
  logic               w_grant;
  logic               w_defer;
  logic               w_retire;
  logic               w_slot_busy;
  logic               w_accept;
  logic               w_dup;

  assign w_head_valid = r_valid[r_head];
  assign w_head_jump  = r_jump[r_head];
  assign w_head_taken = r_taken[r_head];
  assign w_head_pc    = r_pc[r_head];
  assign w_head_tgt   = r_tgt[r_head];

  // Flush blocks every strobe and state change except its own.
  assign w_force  = (r_starve == StarveMax);
  assign w_grant  = ~bus.flush_i & w_head_valid & w_head_jump & (~bus.fetch_rd_i | w_force);
  assign w_defer  = ~bus.flush_i & w_head_valid & w_head_jump & ~w_grant;
  assign w_retire = ~bus.flush_i & w_head_valid & (~w_head_jump | w_grant);

  assign w_slot_busy = r_valid[bus.upd_ticket_i];
  assign w_accept    = bus.upd_valid_i & ~bus.flush_i & ~w_slot_busy;
  assign w_dup       = bus.upd_valid_i & ~bus.flush_i & w_slot_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= '0;
      r_jump   <= '0;
      r_taken  <= '0;
      r_head   <= '0;
      r_starve <= '0;
      r_err    <= 1'b0;
      for (int i = 0; i < Slots; i++) begin
        r_pc[i]  <= '0;
        r_tgt[i] <= '0;
      end
    end else if (bus.flush_i) begin
      r_valid  <= '0;
      r_head   <= bus.flush_ticket_i;
      r_starve <= '0;
    end else begin
      // Accept and retire never target the same slot: the head slot is valid when retiring.
      if (w_accept) begin
        r_valid[bus.upd_ticket_i] <= 1'b1;
        r_jump[bus.upd_ticket_i]  <= bus.upd_valid_jump_i;
        r_taken[bus.upd_ticket_i] <= bus.upd_jump_taken_i;
        r_pc[bus.upd_ticket_i]    <= bus.upd_orig_pc_i;
        r_tgt[bus.upd_ticket_i]   <= bus.upd_jump_address_i;
      end
      if (w_dup) begin
        r_err <= 1'b1;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + TICKET_BITS'(1);
      end
      if (w_grant) begin
        r_starve <= '0;
      end else if (w_defer && (r_starve != StarveMax)) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  assign bus.gsh_upd_en_o    = w_grant;
  assign bus.gsh_upd_pc_o    = w_grant ? w_head_pc : '0;
  assign bus.gsh_upd_taken_o = w_grant & w_head_taken;
  assign bus.btb_wr_en_o     = w_grant & w_head_taken;
  assign bus.btb_wr_pc_o     = (w_grant & w_head_taken) ? w_head_pc : '0;
  assign bus.btb_wr_target_o = (w_grant & w_head_taken) ? w_head_tgt : '0;
  assign bus.fetch_stall_o   = w_grant & bus.fetch_rd_i;
  assign bus.head_ticket_o   = r_head;
  assign bus.pending_o       = |r_valid;
  assign bus.err_o           = r_err;

endmodule
